// File: rtl/cw310_crypt_batch_ctrl.sv
// ---------------------------------------------------------------------------
// cw310_crypt_batch_ctrl
//
// Purpose:
//   Sequencer between the register block and the crypto core. A single start
//   request runs a batch of back-to-back encryptions. Each ciphertext can
//   optionally be chained into the next plaintext. The block drives the core
//   start pulse, the scope trigger, busy, a per-operation timeout and a
//   batch-done pulse.
//
// Ports:
//   crypto_clk        sole clock
//   reset_i           synchronous, active-high reset
//   I_start           one-cycle batch start request (honoured only in IDLE)
//   I_abort           abandon the running batch and return to IDLE
//   I_batch_count     operations per batch, 0 is treated as 1
//   I_chain           1: next plaintext is the previous ciphertext
//   I_textin          first plaintext of the batch
//   I_timeout         max RUN cycles per operation, 0 disables the timeout
//   I_core_ready      core can accept a start
//   I_core_done       core done, level or pulse (only the rising edge is used)
//   I_core_cipherout  core result, valid at the done rising edge
//   O_core_start      one-cycle start pulse to the core
//   O_core_textin     plaintext presented to the core
//   O_trigger         high from the core start cycle until the done edge
//   O_busy            high in every state except IDLE
//   O_done            one-cycle pulse at normal or timeout batch end
//   O_timeout_err     sticky timeout flag, cleared by the next accepted start
//   O_completed       operations completed in the current/last batch
//   O_last_cipherout  most recently captured ciphertext
// ---------------------------------------------------------------------------
module cw310_crypt_batch_ctrl #(
   parameter int pPT_WIDTH      = 128,
   parameter int pCT_WIDTH      = 128,
   parameter int pCOUNT_WIDTH   = 16,
   parameter int pTIMEOUT_WIDTH = 16
) (
   input  logic                      crypto_clk,
   input  logic                      reset_i,
   input  logic                      I_start,
   input  logic                      I_abort,
   input  logic [pCOUNT_WIDTH-1:0]   I_batch_count,
   input  logic                      I_chain,
   input  logic [pPT_WIDTH-1:0]      I_textin,
   input  logic [pTIMEOUT_WIDTH-1:0] I_timeout,
   input  logic                      I_core_ready,
   input  logic                      I_core_done,
   input  logic [pCT_WIDTH-1:0]      I_core_cipherout,
   output logic                      O_core_start,
   output logic [pPT_WIDTH-1:0]      O_core_textin,
   output logic                      O_trigger,
   output logic                      O_busy,
   output logic                      O_done,
   output logic                      O_timeout_err,
   output logic [pCOUNT_WIDTH-1:0]   O_completed,
   output logic [pCT_WIDTH-1:0]      O_last_cipherout
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_RDY,
      LAUNCH,
      RUN,
      FINISH
   } state_e;

   state_e                    state_q;
   logic [pCOUNT_WIDTH-1:0]   batchCount_q;
   logic                      chain_q;
   logic [pTIMEOUT_WIDTH-1:0] timeout_q;
   logic [pTIMEOUT_WIDTH-1:0] timer_q;
   logic                      coreDoneDly_q;
   logic                      coreStart_q;
   logic [pPT_WIDTH-1:0]      textin_q;
   logic                      trigger_q;
   logic                      busy_q;
   logic                      done_q;
   logic                      timeoutErr_q;
   logic [pCOUNT_WIDTH-1:0]   completed_q;
   logic [pCT_WIDTH-1:0]      lastCipher_q;

   logic                      doneEdge;
   logic                      timerExpired;
   logic [pCOUNT_WIDTH-1:0]   completed_d;

   // The core may hold done as a level, so only a low-to-high transition
   // counts as a completed operation. The delayed copy is sampled in every
   // state, which means a level still high from the previous operation when
   // we launch the next one cannot look like a fresh edge once RUN begins.
   // The timeout fires on the last allowed RUN cycle so that a limit of N
   // allows exactly N RUN cycles; zero disables it. The completed count
   // cannot wrap because the batch length itself fits in the counter width.
   always_comb begin
      doneEdge     = I_core_done & ~coreDoneDly_q;
      timerExpired = (timeout_q != '0) && (timer_q == (timeout_q - pTIMEOUT_WIDTH'(1)));
      completed_d  = completed_q + pCOUNT_WIDTH'(1);
   end

   // Batch sequencer. Every output is a register, so each output is written
   // on the transition into the state it belongs to. Start and done are
   // pulses: they default low each cycle and are only raised on the way
   // into LAUNCH or FINISH. Abort is checked ahead of the state case so it
   // beats a simultaneous ready, done edge or timeout. On abort the
   // completed count and captured ciphertext are kept so software can see
   // how far the batch got. The run timer saturates rather than wrapping
   // when the timeout is disabled.
   always_ff @(posedge crypto_clk) begin
      if (reset_i) begin
         state_q       <= IDLE;
         batchCount_q  <= '0;
         chain_q       <= 1'b0;
         timeout_q     <= '0;
         timer_q       <= '0;
         coreDoneDly_q <= 1'b0;
         coreStart_q   <= 1'b0;
         textin_q      <= '0;
         trigger_q     <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         timeoutErr_q  <= 1'b0;
         completed_q   <= '0;
         lastCipher_q  <= '0;
      end else begin
         coreDoneDly_q <= I_core_done;
         coreStart_q   <= 1'b0;
         done_q        <= 1'b0;
         if ((state_q != IDLE) && I_abort) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            trigger_q <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (I_start) begin
                     batchCount_q <= (I_batch_count == '0) ? pCOUNT_WIDTH'(1) : I_batch_count;
                     chain_q      <= I_chain;
                     timeout_q    <= I_timeout;
                     textin_q     <= I_textin;
                     completed_q  <= '0;
                     timeoutErr_q <= 1'b0;
                     busy_q       <= 1'b1;
                     state_q      <= WAIT_RDY;
                  end
               end
               WAIT_RDY: begin
                  if (I_core_ready) begin
                     coreStart_q <= 1'b1;
                     trigger_q   <= 1'b1;
                     timer_q     <= '0;
                     state_q     <= LAUNCH;
                  end
               end
               LAUNCH: begin
                  timer_q <= '0;
                  state_q <= RUN;
               end
               RUN: begin
                  if (doneEdge) begin
                     lastCipher_q <= I_core_cipherout;
                     completed_q  <= completed_d;
                     trigger_q    <= 1'b0;
                     if (chain_q) begin
                        textin_q <= pPT_WIDTH'(I_core_cipherout);
                     end
                     if (completed_d == batchCount_q) begin
                        done_q  <= 1'b1;
                        state_q <= FINISH;
                     end else begin
                        state_q <= WAIT_RDY;
                     end
                  end else if (timerExpired) begin
                     timeoutErr_q <= 1'b1;
                     trigger_q    <= 1'b0;
                     done_q       <= 1'b1;
                     state_q      <= FINISH;
                  end else if (timer_q != '1) begin
                     timer_q <= timer_q + pTIMEOUT_WIDTH'(1);
                  end
               end
               FINISH: begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
               default: begin
                  busy_q    <= 1'b0;
                  trigger_q <= 1'b0;
                  state_q   <= IDLE;
               end
            endcase
         end
      end
   end

   // Outputs come straight from their registers.
   always_comb begin
      O_core_start     = coreStart_q;
      O_core_textin    = textin_q;
      O_trigger        = trigger_q;
      O_busy           = busy_q;
      O_done           = done_q;
      O_timeout_err    = timeoutErr_q;
      O_completed      = completed_q;
      O_last_cipherout = lastCipher_q;
   end

endmodule
